// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment display path.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    CONV_IDLE,
    CONV_SHIFT
  } conv_state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_display_mux_if.sv
// Load handshake between the ALU core (master) and the display stage (slave).
interface seg7_display_mux_if;
  logic [7:0] value;
  logic       value_valid;
  logic       signed_en;
  logic       busy;

  modport master (output value, output value_valid, output signed_en, input busy);
  modport slave  (input value, input value_valid, input signed_en, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit to 3-digit BCD double-dabble converter.
// One iteration per cycle after start; done pulses once the result is final.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [19:0] sreg_q, sreg_d;   // {hundreds, tens, ones, binary}
  logic        done_q, done_d;

  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[8 + 4*i +: 4] >= 4'd5) t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    sreg_d  = sreg_q;
    done_d  = 1'b0;
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          sreg_d  = {12'd0, bin};
          iter_d  = 3'd0;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        sreg_d = dabble_step(sreg_q);
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = CONV_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CONV_IDLE;
      iter_q  <= 3'd0;
      sreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      sreg_q  <= sreg_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = sreg_q[19:8];

endmodule

// File: rtl/seg7_display_mux.sv
// Converts the ALU result to signed/unsigned decimal and scans it onto a
// 4-digit common-anode display with leading-zero blanking and global blank.
module seg7_display_mux
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SIGNED_DEFAULT = 1'b1
) (
  input  logic                  Clk,
  input  logic                  reset,
  seg7_display_mux_if.slave     load,
  input  logic                  blank,
  output logic [NUM_DIGITS-1:0] AN_SEL,
  output logic [6:0]            seven_seg_out
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic        busy_q;
  logic        pend_q;
  logic [7:0]  pend_value_q;
  logic        pend_signed_q;
  logic        signed_q;
  logic        msb_q;
  logic [11:0] disp_bcd_q;
  logic        disp_sign_q;

  logic        start;
  logic [7:0]  src_value;
  logic        src_signed;
  logic [7:0]  magnitude;
  logic        conv_done;
  logic [11:0] conv_bcd;

  // A fresh strobe on an idle cycle supersedes whatever is pending.
  always_comb begin
    src_value  = pend_value_q;
    src_signed = pend_signed_q;
    if (load.value_valid) begin
      src_value  = load.value;
      src_signed = load.signed_en;
    end
    start     = !busy_q && (load.value_valid || pend_q);
    magnitude = (src_signed && src_value[7]) ? (~src_value + 8'd1) : src_value;
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (Clk),
    .rst_n (reset),
    .start (start),
    .bin   (magnitude),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      busy_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_value_q  <= 8'd0;
      pend_signed_q <= 1'b0;
      signed_q      <= SIGNED_DEFAULT;
      msb_q         <= 1'b0;
      disp_bcd_q    <= 12'd0;
      disp_sign_q   <= 1'b0;
    end else begin
      if (start) begin
        busy_q   <= 1'b1;
        pend_q   <= 1'b0;
        signed_q <= src_signed;
        msb_q    <= src_value[7];
      end else if (busy_q && conv_done) begin
        busy_q      <= 1'b0;
        disp_bcd_q  <= conv_bcd;
        disp_sign_q <= signed_q & msb_q;
      end
      if (busy_q && load.value_valid) begin
        pend_q        <= 1'b1;
        pend_value_q  <= load.value;
        pend_signed_q <= load.signed_en;
      end
    end
  end

  assign load.busy = busy_q;

  logic [CNT_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [NUM_DIGITS-1:0] an_slot;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  wrap;

  assign wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

  always_comb begin
    an_next = ~(NUM_DIGITS'(1) << digit_idx);
    case (digit_idx)
      IDX_W'(0): seg_next = bcd_to_seg(disp_bcd_q[3:0]);
      IDX_W'(1): seg_next = (disp_bcd_q[11:4] == 8'd0) ? SEG_BLANK : bcd_to_seg(disp_bcd_q[7:4]);
      IDX_W'(2): seg_next = (disp_bcd_q[11:8] == 4'd0) ? SEG_BLANK : bcd_to_seg(disp_bcd_q[11:8]);
      default:   seg_next = disp_sign_q ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  // Anode and segments for a slot load on the same edge; blank only masks anodes.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt   <= '0;
      digit_idx     <= '0;
      an_slot       <= '1;
      AN_SEL        <= '1;
      seven_seg_out <= SEG_BLANK;
    end else begin
      if (wrap) begin
        refresh_cnt   <= '0;
        digit_idx     <= digit_idx + IDX_W'(1);
        an_slot       <= an_next;
        seven_seg_out <= seg_next;
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      AN_SEL <= blank ? '1 : (wrap ? an_next : an_slot);
    end
  end

endmodule

// File: tb/tb_seg7_display_mux.sv
// Randomized scoreboard bench for seg7_display_mux: stimulus queues the value
// each conversion should display, a monitor checks the scan every cycle.
module tb_seg7_display_mux;

  localparam int REFRESH_DIV = 4;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    int mag;
    bit neg;
  } exp_t;

  logic       Clk;
  logic       reset;
  logic       blank;
  logic [3:0] AN_SEL;
  logic [6:0] seven_seg_out;

  seg7_display_mux_if ld ();

  seg7_display_mux #(.REFRESH_DIV(REFRESH_DIV), .SIGNED_DEFAULT(1'b1)) dut (
    .Clk           (Clk),
    .reset         (reset),
    .load          (ld),
    .blank         (blank),
    .AN_SEL        (AN_SEL),
    .seven_seg_out (seven_seg_out)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  // Reference model of the conversion pipeline in edge-number terms.
  int conv_start = -1000;
  bit pend_v     = 1'b0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int mag, input bit neg, input int slot);
    case (slot)
      0:       return SEG_TAB[mag % 10];
      1:       return (mag >= 10)  ? SEG_TAB[(mag / 10) % 10] : 7'b1111111;
      2:       return (mag >= 100) ? SEG_TAB[mag / 100] : 7'b1111111;
      default: return neg ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  // Called just after a negedge; the strobe is sampled at edge cyc+1.
  task automatic strobe(input logic [7:0] v, input logic s);
    int   e;
    exp_t x;
    e = cyc + 1;
    if (s && v[7]) begin
      x.mag = 256 - int'(v);
      x.neg = 1'b1;
    end else begin
      x.mag = int'(v);
      x.neg = 1'b0;
    end
    if (pend_v && e > conv_start + 10) begin
      conv_start = conv_start + 10;
      pend_v     = 1'b0;
    end
    if (pend_v && e == conv_start + 10) begin
      exp_q[exp_q.size() - 1] = x;
      conv_start = e;
      pend_v     = 1'b0;
    end else if (e >= conv_start + 10) begin
      exp_q.push_back(x);
      conv_start = e;
    end else if (pend_v) begin
      exp_q[exp_q.size() - 1] = x;
    end else begin
      exp_q.push_back(x);
      pend_v = 1'b1;
    end
    ld.value       = v;
    ld.signed_en   = s;
    ld.value_valid = 1'b1;
    @(negedge Clk);
    ld.value_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (ld.busy !== 1'b0 && k < budget) begin
      @(negedge Clk);
      k++;
    end
    if (k >= budget) check("wait_idle_timeout", ld.busy, 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    conv_start = -1000;
    pend_v     = 1'b0;
  endtask

  // Monitor: samples inputs at the edge and checks outputs 1 time unit later.
  initial begin : monitor
    int         n, busy_run, slot;
    bit         prev_busy, b, r;
    exp_t       cur, x;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    n = 0; busy_run = 0; prev_busy = 1'b0;
    cur.mag = 0; cur.neg = 1'b0; exp_seg = 7'b1111111;
    forever begin
      @(posedge Clk);
      b = blank;
      r = reset;
      #1;
      if (!r) begin
        n = 0; busy_run = 0; prev_busy = 1'b0;
        cur.mag = 0; cur.neg = 1'b0; exp_seg = 7'b1111111;
        check("rst_an", AN_SEL, 4'b1111);
        check("rst_seg", seven_seg_out, 7'b1111111);
        check("rst_busy", ld.busy, 0);
      end else begin
        n++;
        slot = (n / REFRESH_DIV - 1) % 4;
        if (n >= REFRESH_DIV && n % REFRESH_DIV == 0) exp_seg = model_seg(cur.mag, cur.neg, slot);
        exp_an = (b || n < REFRESH_DIV) ? 4'b1111 : ~(4'b0001 << slot);
        check("scan_an", AN_SEL, exp_an);
        check("scan_seg", seven_seg_out, exp_seg);
        if (ld.busy === 1'b1) begin
          busy_run++;
        end else if (prev_busy) begin
          check("busy_len", busy_run, 9);
          busy_run = 0;
          check("commit_has_expect", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            x   = exp_q.pop_front();
            cur = x;
          end
        end
        prev_busy = (ld.busy === 1'b1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] rv;
    logic       rs;
    reset = 1'b0; blank = 1'b0;
    ld.value = 8'd0; ld.value_valid = 1'b0; ld.signed_en = 1'b0;
    model_reset();
    repeat (10) @(negedge Clk);
    reset = 1'b1;
    repeat (24) @(negedge Clk);

    strobe(8'h0F, 1'b0); wait_idle(20); repeat (24) @(negedge Clk);
    strobe(8'h80, 1'b1); wait_idle(20); repeat (24) @(negedge Clk);
    strobe(8'h80, 1'b0); wait_idle(20); repeat (24) @(negedge Clk);
    strobe(8'hF6, 1'b1); wait_idle(20); repeat (24) @(negedge Clk);

    // Overlapping loads: 200 is overwritten in the pending slot by 42.
    strobe(8'd5, 1'b0);
    repeat (2) @(negedge Clk);
    strobe(8'd200, 1'b0);
    @(negedge Clk);
    strobe(8'd42, 1'b0);
    wait_idle(20);
    @(negedge Clk);
    check("pend_gap_one_cycle", ld.busy, 1);
    wait_idle(20); repeat (24) @(negedge Clk);

    // Reset in the middle of a conversion.
    strobe(8'd99, 1'b0);
    repeat (3) @(negedge Clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_an", AN_SEL, 4'b1111);
    check("async_rst_seg", seven_seg_out, 7'b1111111);
    check("async_rst_busy", ld.busy, 0);
    repeat (3) @(negedge Clk);
    reset = 1'b1;
    repeat (24) @(negedge Clk);

    blank = 1'b1;
    repeat (20) @(negedge Clk);
    blank = 1'b0;
    repeat (12) @(negedge Clk);

    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) blank = ~blank;
      strobe(rv, rs);
      repeat ($urandom_range(0, 14)) @(negedge Clk);
    end
    blank = 1'b0;
    wait_idle(40);
    repeat (40) @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
